// File: rtl/ariane_pkg.sv
// Shared front-end types: fetch exception, branch-prediction hint and the
// fetch_entry handed from the fetch FIFO to decode.
package ariane_pkg;

  localparam int unsigned FETCH_FIFO_DEPTH = 8;

  localparam logic [63:0] INSTR_ACCESS_FAULT = 64'd1;
  localparam logic [63:0] INSTR_PAGE_FAULT   = 64'd12;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [63:0] predict_address;
    logic        predict_taken;
    logic        valid;
  } branchpredict_sbe;

  typedef struct packed {
    logic [63:0]      address;
    logic [31:0]      instruction;
    branchpredict_sbe branch_predict;
    exception         ex;
    logic             is_compressed;
    logic             is_illegal;
  } fetch_entry;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue between fetch and decode. Buffers fetched words with PC,
// prediction hint and fetch exception; drains in order over valid/ready and
// drops everything on flush_i.
// Optional: FETCH_FIFO_BYPASS_EN lets an entry arriving at an empty FIFO reach
// the output in the same cycle.
module fetch_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [63:0]                in_addr_i,
  input  logic [31:0]                in_instr_i,
  input  branchpredict_sbe           in_bp_i,
  input  exception                   in_ex_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output fetch_entry                 fetch_entry_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Compressed when the low two bits are not 2'b11; legality is decode's job.
  function automatic fetch_entry build_entry(input logic [63:0]      addr,
                                             input logic [31:0]      instr,
                                             input branchpredict_sbe bp,
                                             input exception         ex);
    fetch_entry e;
    e.address        = addr;
    e.instruction    = instr;
    e.branch_predict = bp;
    e.ex             = ex;
    e.is_compressed  = (instr[1:0] != 2'b11);
    e.is_illegal     = 1'b0;
    return e;
  endfunction

  fetch_entry            mem_q [DEPTH];
  logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]       count_q;
  fetch_entry            entry_in;
  logic                  empty, full, push, pop, bypass;

  assign entry_in   = build_entry(in_addr_i, in_instr_i, in_bp_i, in_ex_i);
  assign empty      = (count_q == '0);
  assign full       = (count_q == CntW'(DEPTH));
  assign in_ready_o = ~full;
  assign count_o    = count_q;

  // Handshake decode and output selection.
  always_comb begin
    bypass        = 1'b0;
    out_valid_o   = ~empty;
    fetch_entry_o = mem_q[rd_ptr_q];
    pop           = ~empty & out_ready_i & ~flush_i;
    push          = in_valid_i & ~full & ~flush_i;
`ifdef FETCH_FIFO_BYPASS_EN
    bypass = empty & in_valid_i;
    if (bypass) begin
      out_valid_o   = 1'b1;
      fetch_entry_o = entry_in;
      // Consumed straight through: nothing to store.
      if (out_ready_i) push = 1'b0;
    end
`endif
  end

  // Storage is deliberately not reset; only occupied slots are ever read out.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= entry_in;
  end

  // Pointers and occupancy; flush dominates any handshake in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  logic unused_bypass;
  assign unused_bypass = bypass;

endmodule

// File: tb/tb_fetch_fifo.sv
// Self-checking bench for fetch_fifo: a scoreboard queue holds expected
// entries in acceptance order and is checked against every pop.
// Build with FETCH_FIFO_BYPASS_EN defined to cover the bypass path.
module tb_fetch_fifo;
  import ariane_pkg::*;

  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_addr;
  logic [31:0]      in_instr;
  branchpredict_sbe in_bp;
  exception         in_ex;
  logic             out_valid;
  logic             out_ready;
  fetch_entry       out_entry;
  logic [3:0]       count;

  int vectors     = 0;
  int miscompares = 0;

  fetch_entry sb[$];
  int         mcount = 0;

  fetch_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_addr_i    (in_addr),
    .in_instr_i   (in_instr),
    .in_bp_i      (in_bp),
    .in_ex_i      (in_ex),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .fetch_entry_o(out_entry),
    .count_o      (count)
  );

  always #5 clk = ~clk;

  function automatic fetch_entry exp_entry(input logic [63:0] a, input logic [31:0] i,
                                           input branchpredict_sbe b, input exception e);
    fetch_entry r;
    r.address        = a;
    r.instruction    = i;
    r.branch_predict = b;
    r.ex             = e;
    r.is_compressed  = (i[1:0] != 2'b11);
    r.is_illegal     = 1'b0;
    return r;
  endfunction

  // Reference model: inputs are stable from posedge+1 to the next posedge,
  // so the negedge sees exactly what the coming edge will act on.
  always @(negedge clk) begin
    bit         bypass, push, pop;
    fetch_entry e;
    if (rst) begin
      sb.delete();
      mcount = 0;
    end else begin
      bypass = 1'b0;
`ifdef FETCH_FIFO_BYPASS_EN
      bypass = (mcount == 0) && in_valid;
`endif
      vectors++;
      if (in_ready !== (mcount != DEPTH)) begin
        miscompares++;
        $display("FAIL in_ready: got %b expected %b", in_ready, mcount != DEPTH);
      end
      vectors++;
      if (out_valid !== ((mcount != 0) || bypass)) begin
        miscompares++;
        $display("FAIL out_valid: got %b expected %b", out_valid, (mcount != 0) || bypass);
      end
      vectors++;
      if (count !== 4'(mcount)) begin
        miscompares++;
        $display("FAIL count: got %0d expected %0d", count, mcount);
      end
      if (flush) begin
        sb.delete();
        mcount = 0;
      end else if (bypass && out_ready) begin
        e = exp_entry(in_addr, in_instr, in_bp, in_ex);
        vectors++;
        if (out_entry !== e) begin
          miscompares++;
          $display("FAIL bypass_entry: got %h expected %h", out_entry, e);
        end
      end else begin
        pop  = (mcount != 0) && out_ready;
        push = in_valid && (mcount != DEPTH);
        if (pop) begin
          e = sb.pop_front();
          vectors++;
          if (out_entry !== e) begin
            miscompares++;
            $display("FAIL pop_entry: got %h expected %h", out_entry, e);
          end
        end
        if (push) sb.push_back(exp_entry(in_addr, in_instr, in_bp, in_ex));
        mcount = mcount + int'(push) - int'(pop);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [63:0] a, input logic [31:0] i);
    in_valid = 1'b1;
    in_addr  = a;
    in_instr = i;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && count != 0; i++) cycle();
    out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (count !== 4'd0) begin
      miscompares++;
      $display("FAIL drain_timeout: got count %0d expected 0", count);
    end
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_addr = '0; in_instr = '0; in_bp = '0; in_ex = '0;
    repeat (3) cycle();
    rst = 1'b0;
    repeat (2) cycle();
    @(negedge clk);
    vectors++;
    if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL reset_idle: got v=%b r=%b c=%0d expected v=0 r=1 c=0",
               out_valid, in_ready, count);
    end
    cycle();
  endtask

  task automatic test_basic();
    push_one(64'h8000_0000, 32'h0000_0013);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_entry.address !== 64'h8000_0000 ||
        out_entry.is_compressed !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_head: got v=%b a=%h c=%b expected v=1 a=80000000 c=0",
               out_valid, out_entry.address, out_entry.is_compressed);
    end
    cycle();
    push_one(64'h8000_0004, 32'h0000_4501);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_entry.address !== 64'h8000_0004 || out_entry.is_compressed !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_compressed: got a=%h c=%b expected a=80000004 c=1",
               out_entry.address, out_entry.is_compressed);
    end
    cycle();
    drain();
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_one(64'h8000_0000 + 64'(4 * i), 32'h0000_0013);
    in_valid = 1'b1;
    in_addr  = 64'h8000_0020;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || count !== 4'd8) begin
      miscompares++;
      $display("FAIL full: got r=%b c=%0d expected r=0 c=8", in_ready, count);
    end
    cycle();
    // Push and pop together while full: only the pop happens.
    in_addr   = 64'h9000_0000;
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_entry.address !== 64'h8000_0000) begin
      miscompares++;
      $display("FAIL full_head: got %h expected 80000000", out_entry.address);
    end
    cycle();
    in_addr = 64'h9000_0004;
    @(negedge clk);
    vectors++;
    if (count !== 4'd7) begin
      miscompares++;
      $display("FAIL full_pushpop: got %0d expected 7", count);
    end
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (count !== 4'd7) begin
      miscompares++;
      $display("FAIL steady_pushpop: got %0d expected 7", count);
    end
    cycle();
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push_one(64'hC000_0000 + 64'(4 * i), 32'h0000_0013);
    in_valid = 1'b1;
    in_addr  = 64'hDEAD_0000;
    flush    = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL flush: got v=%b r=%b c=%0d expected v=0 r=1 c=0",
               out_valid, in_ready, count);
    end
    cycle();
    push_one(64'hA000_0000, 32'h0000_0013);
    @(negedge clk);
    vectors++;
    if (out_entry.address !== 64'hA000_0000) begin
      miscompares++;
      $display("FAIL flush_after: got %h expected a0000000", out_entry.address);
    end
    cycle();
    drain();
  endtask

  task automatic test_exception();
    exception e;
    e.cause = INSTR_PAGE_FAULT;
    e.tval  = 64'h8000_1000;
    e.valid = 1'b1;
    in_ex   = e;
    push_one(64'h8000_1000, 32'h0000_0000);
    in_ex = '0;
    @(negedge clk);
    vectors++;
    if (out_entry.ex !== e) begin
      miscompares++;
      $display("FAIL exception: got %h expected %h", out_entry.ex, e);
    end
    cycle();
    drain();
  endtask

  task automatic test_bypass();
`ifdef FETCH_FIFO_BYPASS_EN
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_addr   = 64'hB000_0000;
    in_instr  = 32'h0000_0013;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || count !== 4'd0 || out_entry.address !== 64'hB000_0000) begin
      miscompares++;
      $display("FAIL bypass: got v=%b c=%0d a=%h expected v=1 c=0 a=b0000000",
               out_valid, count, out_entry.address);
    end
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (count !== 4'd0) begin
      miscompares++;
      $display("FAIL bypass_count: got %0d expected 0", count);
    end
    cycle();
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_addr   = {$urandom, $urandom};
      in_instr  = $urandom;
      in_bp     = {$urandom, $urandom, 2'($urandom)};
      in_ex     = '0;
      in_ex.valid = ($urandom_range(0, 7) == 0);
      in_ex.cause = in_ex.valid ? INSTR_PAGE_FAULT : 64'd0;
      cycle();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    in_bp    = '0;
    in_ex    = '0;
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push_one(64'hE000_0000 + 64'(4 * i), 32'h0000_0013);
    rst = 1'b1;
    #2;
    vectors++;
    if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%b r=%b c=%0d expected v=0 r=1 c=0",
               out_valid, in_ready, count);
    end
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_flush();
    test_exception();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
